// File: rtl/particle_renderer.sv
// Particle renderer: erases last frame's particles, fetches the current list and draws it.
// Define RENDER_SPRITE_2X2_EN to draw/erase each particle as a clipped 2x2 sprite.
module particle_renderer #(
  parameter int         N_OBJ       = 8,
  parameter logic [2:0] ERASE_COLOR = 3'b000,
  localparam int        IDX_W       = $clog2(N_OBJ)
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             frame_start,
  output logic             obj_req,
  output logic [IDX_W-1:0] obj_idx,
  input  logic             obj_valid,
  input  logic [5:0]       obj_x,
  input  logic [5:0]       obj_y,
  input  logic [2:0]       obj_color,
  output logic             write_en,
  output logic [5:0]       write_x,
  output logic [5:0]       write_y,
  output logic [2:0]       write_color,
  output logic             busy,
  output logic             frame_done
);

`ifdef RENDER_SPRITE_2X2_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_FETCH, S_DRAW, S_DONE} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_slot;
  logic [1:0]       r_sub;
  logic [5:0]       r_cap_x, r_cap_y;
  logic [2:0]       r_cap_c;
  logic             r_obj_req;
  logic [IDX_W-1:0] r_obj_idx;
  logic             r_write_en;
  logic [5:0]       r_write_x, r_write_y;
  logic [2:0]       r_write_color;
  logic             r_busy, r_frame_done;

  logic [N_OBJ-1:0] r_sh_v;
  logic [5:0]       r_sh_x [N_OBJ];
  logic [5:0]       r_sh_y [N_OBJ];

  logic       w_xfer, w_last_slot, w_last_sub, w_in;
  logic [5:0] w_src_x, w_src_y;
  logic [6:0] w_px, w_py;

  assign w_xfer      = (r_state == S_FETCH) && r_obj_req && obj_valid;
  assign w_last_slot = (r_slot == IDX_W'(N_OBJ - 1));
  assign w_last_sub  = (r_sub == 2'(P - 1));

  // Sub-pixel order (x,y),(x+1,y),(x,y+1),(x+1,y+1); bit 6 set means off-panel.
  assign w_src_x = (r_state == S_ERASE) ? r_sh_x[r_slot] : r_cap_x;
  assign w_src_y = (r_state == S_ERASE) ? r_sh_y[r_slot] : r_cap_y;
  assign w_px    = {1'b0, w_src_x} + 7'(r_sub[0]);
  assign w_py    = {1'b0, w_src_y} + 7'(r_sub[1]);
  assign w_in    = !w_px[6] && !w_py[6];

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_sh_v <= '0;
    end else if (w_xfer) begin
      r_sh_v[r_slot] <= (obj_color != 3'b000);
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_xfer) begin
      r_sh_x[r_slot] <= obj_x;
      r_sh_y[r_slot] <= obj_y;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_slot        <= '0;
      r_sub         <= '0;
      r_cap_x       <= '0;
      r_cap_y       <= '0;
      r_cap_c       <= '0;
      r_obj_req     <= 1'b0;
      r_obj_idx     <= '0;
      r_write_en    <= 1'b0;
      r_write_x     <= '0;
      r_write_y     <= '0;
      r_write_color <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_write_en   <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_state <= S_ERASE;
            r_slot  <= '0;
            r_sub   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_ERASE: begin
          r_write_en    <= r_sh_v[r_slot] && w_in;
          r_write_x     <= w_px[5:0];
          r_write_y     <= w_py[5:0];
          r_write_color <= ERASE_COLOR;
          if (w_last_sub) begin
            r_sub <= '0;
            if (w_last_slot) begin
              r_slot  <= '0;
              r_state <= S_FETCH;
            end else begin
              r_slot <= r_slot + IDX_W'(1);
            end
          end else begin
            r_sub <= r_sub + 2'd1;
          end
        end
        S_FETCH: begin
          if (!r_obj_req) begin
            r_obj_req <= 1'b1;
            r_obj_idx <= r_slot;
          end else if (obj_valid) begin
            r_obj_req <= 1'b0;
            r_cap_x   <= obj_x;
            r_cap_y   <= obj_y;
            r_cap_c   <= obj_color;
            if (obj_color != 3'b000) begin
              r_state <= S_DRAW;
              r_sub   <= '0;
            end else if (w_last_slot) begin
              r_state <= S_DONE;
            end else begin
              r_slot <= r_slot + IDX_W'(1);
            end
          end
        end
        S_DRAW: begin
          r_write_en    <= w_in;
          r_write_x     <= w_px[5:0];
          r_write_y     <= w_py[5:0];
          r_write_color <= r_cap_c;
          if (w_last_sub) begin
            r_sub <= '0;
            if (w_last_slot) begin
              r_state <= S_DONE;
            end else begin
              r_slot  <= r_slot + IDX_W'(1);
              r_state <= S_FETCH;
            end
          end else begin
            r_sub <= r_sub + 2'd1;
          end
        end
        S_DONE: begin
          r_frame_done <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign obj_req     = r_obj_req;
  assign obj_idx     = r_obj_idx;
  assign write_en    = r_write_en;
  assign write_x     = r_write_x;
  assign write_y     = r_write_y;
  assign write_color = r_write_color;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_particle_renderer.sv
// Randomised self-checking bench for particle_renderer (N_OBJ=4) against a pixel-list model.
module tb_particle_renderer;
  localparam int N = 4;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       obj_req;
  logic [1:0] obj_idx;
  logic       obj_valid = 1'b0;
  logic [5:0] obj_x = '0, obj_y = '0;
  logic [2:0] obj_color = '0;
  logic       write_en;
  logic [5:0] write_x, write_y;
  logic [2:0] write_color;
  logic       busy, frame_done;

  particle_renderer #(.N_OBJ(N)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .frame_start(frame_start),
    .obj_req(obj_req), .obj_idx(obj_idx), .obj_valid(obj_valid),
    .obj_x(obj_x), .obj_y(obj_y), .obj_color(obj_color),
    .write_en(write_en), .write_x(write_x), .write_y(write_y),
    .write_color(write_color), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  // Physics-core contents for the current frame, plus per-slot valid delay.
  logic [5:0] tab_x [N];
  logic [5:0] tab_y [N];
  logic [2:0] tab_c [N];
  int         tab_d [N];
  bit         tied = 1'b0;

  // Model of what the panel was last drawn with.
  bit         m_v [N];
  logic [5:0] m_x [N];
  logic [5:0] m_y [N];

  logic [14:0] got_q [$];
  logic [14:0] exp_q [$];
  int          xfer_q [$];
  int fd_cnt = 0, busy_bad = 0, overlap = 0, req_hi1 = 0, x1_cnt = 0;
  bit mon_pass = 1'b0, armed = 1'b0;
  int cnt = 0;
  int tests = 0, fails = 0;

  // Monitor and physics-core responder, all on the falling edge.
  initial begin
    forever begin
      @(negedge clk_in);
      if (write_en) got_q.push_back({write_x, write_y, write_color});
      if (frame_done) fd_cnt++;
      if (write_en && obj_req) overlap++;
      if (obj_req && obj_idx == 2'd1) req_hi1++;
      if (!reset_n) mon_pass = 1'b0;
      else begin
        if (frame_done) mon_pass = 1'b0;
        else if (mon_pass && !busy) busy_bad++;
        if (frame_start && !busy && !frame_done) mon_pass = 1'b1;
      end
      if (tied) begin
        obj_valid = 1'b1;
        obj_x = tab_x[obj_idx]; obj_y = tab_y[obj_idx]; obj_color = tab_c[obj_idx];
        if (obj_req) begin
          xfer_q.push_back(int'(obj_idx));
          if (obj_idx == 2'd1) x1_cnt++;
        end
      end else if (obj_valid) begin
        if (!obj_req) obj_valid = 1'b0;
      end else if (obj_req) begin
        if (!armed) begin armed = 1'b1; cnt = tab_d[obj_idx]; end
        if (cnt == 0) begin
          obj_valid = 1'b1; armed = 1'b0;
          obj_x = tab_x[obj_idx]; obj_y = tab_y[obj_idx]; obj_color = tab_c[obj_idx];
          xfer_q.push_back(int'(obj_idx));
          if (obj_idx == 2'd1) x1_cnt++;
        end else cnt--;
      end
    end
  end

  task automatic add_px(input int x, input int y, input logic [2:0] c);
    int d;
`ifdef RENDER_SPRITE_2X2_EN
    d = 1;
`else
    d = 0;
`endif
    for (int dy = 0; dy <= d; dy++)
      for (int dx = 0; dx <= d; dx++)
        if (x + dx <= 63 && y + dy <= 63)
          exp_q.push_back({6'(x + dx), 6'(y + dy), c});
  endtask

  task automatic set_slot(input int s, input int x, input int y, input logic [2:0] c, input int d);
    tab_x[s] = 6'(x); tab_y[s] = 6'(y); tab_c[s] = c; tab_d[s] = d;
  endtask

  task automatic clear_tab();
    for (int s = 0; s < N; s++) set_slot(s, 0, 0, 3'b000, 0);
  endtask

  task automatic run_frame(input bit repulse, input string name);
    int gb, xb, fb, bb, ob, cyc;
    exp_q.delete();
    for (int s = 0; s < N; s++) if (m_v[s]) add_px(m_x[s], m_y[s], 3'b000);
    for (int s = 0; s < N; s++) if (tab_c[s] != 3'b000) add_px(tab_x[s], tab_y[s], tab_c[s]);
    for (int s = 0; s < N; s++) begin
      m_v[s] = (tab_c[s] != 3'b000); m_x[s] = tab_x[s]; m_y[s] = tab_y[s];
    end
    gb = got_q.size(); xb = xfer_q.size(); fb = fd_cnt; bb = busy_bad; ob = overlap;
    @(posedge clk_in); #1 frame_start = 1'b1;
    @(posedge clk_in); #1 frame_start = 1'b0;
    cyc = 0;
    while (fd_cnt == fb && cyc < 3000) begin
      @(posedge clk_in); #1;
      cyc++;
      frame_start = repulse && (cyc == 2 || cyc == 6);
    end
    frame_start = 1'b0;
    repeat (6) @(posedge clk_in);
    #1;
    tests++;
    if (fd_cnt - fb !== 1) begin
      fails++; $display("FAIL %s frame_done: got %0d pulses, want 1", name, fd_cnt - fb);
    end
    tests++;
    if (got_q.size() - gb !== exp_q.size()) begin
      fails++; $display("FAIL %s write count: got %0d, want %0d", name, got_q.size() - gb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
      tests++;
      if (got_q[gb + i] !== exp_q[i]) begin
        fails++;
        $display("FAIL %s write[%0d]: got x=%0d y=%0d c=%0d, want x=%0d y=%0d c=%0d", name, i,
                 got_q[gb+i][14:9], got_q[gb+i][8:3], got_q[gb+i][2:0],
                 exp_q[i][14:9], exp_q[i][8:3], exp_q[i][2:0]);
      end
    end
    tests++;
    if (xfer_q.size() - xb !== N) begin
      fails++; $display("FAIL %s transfers: got %0d, want %0d", name, xfer_q.size() - xb, N);
    end
    for (int i = 0; i < N && xb + i < xfer_q.size(); i++) begin
      tests++;
      if (xfer_q[xb + i] !== i) begin
        fails++; $display("FAIL %s xfer[%0d]: got idx %0d, want %0d", name, i, xfer_q[xb + i], i);
      end
    end
    tests++;
    if (busy_bad !== bb) begin
      fails++; $display("FAIL %s busy: low for %0d pass cycles, want 0", name, busy_bad - bb);
    end
    tests++;
    if (overlap !== ob) begin
      fails++; $display("FAIL %s write_en during obj_req: %0d cycles, want 0", name, overlap - ob);
    end
    $display("[TB] frame %s: %0d writes, %0d transfers", name, got_q.size() - gb, xfer_q.size() - xb);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    tests++;
    if ({write_en, write_x, write_y, write_color, obj_req, obj_idx, busy, frame_done} !== '0) begin
      fails++;
      $display("FAIL reset outputs: got we=%b x=%0d y=%0d c=%0d req=%b idx=%0d busy=%b fd=%b, want all 0",
               write_en, write_x, write_y, write_color, obj_req, obj_idx, busy, frame_done);
    end
    for (int s = 0; s < N; s++) m_v[s] = 1'b0;
    reset_n = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_empty_tied();
    tied = 1'b1; clear_tab();
    run_frame(1'b0, "empty_tied");
    tied = 1'b0;
  endtask

  task automatic test_move();
    clear_tab(); set_slot(2, 10, 20, 3'b101, 0);
    run_frame(1'b0, "move1");
    set_slot(2, 11, 20, 3'b101, 1);
    run_frame(1'b0, "move2");
  endtask

  task automatic test_delay();
    int rb;
    clear_tab(); set_slot(1, 30, 40, 3'b011, 5); set_slot(3, 1, 2, 3'b001, 0);
    rb = req_hi1;
    run_frame(1'b0, "delay");
    tests++;
    if (req_hi1 - rb < 5) begin
      fails++; $display("FAIL delay req hold: got %0d cycles, want >= 5", req_hi1 - rb);
    end
  endtask

  task automatic test_repulse();
    clear_tab(); set_slot(0, 7, 8, 3'b100, 2); set_slot(3, 62, 9, 3'b111, 0);
    run_frame(1'b1, "repulse");
    clear_tab();
    run_frame(1'b0, "after_repulse");
  endtask

  task automatic test_reset_mid();
    int xb, fb, k;
    clear_tab(); set_slot(0, 3, 3, 3'b010, 0); set_slot(1, 20, 21, 3'b110, 0);
    run_frame(1'b0, "pre_reset");
    xb = x1_cnt; fb = fd_cnt;
    @(posedge clk_in); #1 frame_start = 1'b1;
    @(posedge clk_in); #1 frame_start = 1'b0;
    k = 0;
    while (x1_cnt == xb && k < 500) begin @(posedge clk_in); k++; end
    #1 reset_n = 1'b0;
    @(posedge clk_in); #1;
    tests++;
    if ({write_en, write_x, write_y, write_color, obj_req, obj_idx, busy, frame_done} !== '0 || k >= 500) begin
      fails++;
      $display("FAIL reset_mid outputs: got we=%b req=%b busy=%b fd=%b waited=%0d, want zeros", write_en, obj_req, busy, frame_done, k);
    end
    @(posedge clk_in); #1 reset_n = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    tests++;
    if (fd_cnt !== fb) begin
      fails++; $display("FAIL reset_mid frame_done: got %0d pulses, want 0", fd_cnt - fb);
    end
    for (int s = 0; s < N; s++) m_v[s] = 1'b0;
    clear_tab();
    run_frame(1'b0, "post_reset");
  endtask

  task automatic test_corner();
    clear_tab(); set_slot(0, 63, 63, 3'b010, 0); set_slot(1, 5, 5, 3'b110, 1);
    run_frame(1'b0, "corner");
    set_slot(0, 63, 10, 3'b001, 0); set_slot(1, 10, 63, 3'b111, 0);
    run_frame(1'b0, "edges");
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      for (int s = 0; s < N; s++) begin
        set_slot(s,
                 ($urandom_range(0, 3) == 0) ? 63 - $urandom_range(0, 1) : $urandom_range(0, 63),
                 ($urandom_range(0, 3) == 0) ? 63 - $urandom_range(0, 1) : $urandom_range(0, 63),
                 ($urandom_range(0, 9) < 4) ? 3'b000 : 3'($urandom_range(1, 7)),
                 $urandom_range(0, 3));
      end
      tied = (f == 3);
      run_frame(1'b0, $sformatf("random%0d", f));
    end
    tied = 1'b0;
  endtask

  initial begin
    clear_tab();
    test_reset();
    test_empty_tied();
    test_move();
    test_delay();
    test_repulse();
    test_reset_mid();
    test_corner();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/particle_renderer.md
Name: particle_renderer

Overview:
Writer-side master for the LED panel's pixel-memory write port (write_en/write_x/write_y/write_color). On each frame tick it erases the particles it drew last frame, then fetches the current particle list from the physics core over a req/valid handshake. It draws each active particle into the 64x64, 3-bit-colour display memory, at one pixel write per cycle.

Parameters:
N_OBJ, 8, number of particle slots fetched per frame (2..32); slot index width IDX_W = $clog2(N_OBJ)
ERASE_COLOR, 3'b000, colour written when erasing old positions

Ports:
clk_in  input  1  system clock, same domain as the display memory write port
reset_n  input  1  synchronous, active-low reset
frame_start  input  1  one-cycle pulse; starts a render pass when idle
obj_req  output  1  particle fetch request
obj_idx  output  IDX_W  slot being requested
obj_valid  input  1  particle data valid; transfer occurs when obj_req && obj_valid
obj_x  input  6  particle column 0-63
obj_y  input  6  particle row 0-63
obj_color  input  3  particle colour; 3'b000 = slot inactive
write_en  output  1  pixel write strobe to display memory
write_x  output  6  pixel column
write_y  output  6  pixel row
write_color  output  3  pixel colour
busy  output  1  render pass in progress
frame_done  output  1  one-cycle pulse at end of pass

Behaviour:
- All outputs are registered. Reset values: write_en=0, write_x=0, write_y=0, write_color=0, obj_req=0, obj_idx=0, busy=0, frame_done=0.
- Internal shadow list holds N_OBJ entries of {valid, x[5:0], y[5:0]}. Reset clears every valid bit. Reset does not touch the panel.
- States: IDLE, ERASE, FETCH, DRAW, DONE.
- IDLE: busy=0. A cycle where frame_start=1 moves to ERASE with slot=0, sub=0, and busy=1 from the next cycle. frame_start is ignored in every other state.
- ERASE: each slot takes P cycles, where P=1 by default. If shadow valid, write_en=1 with the shadow x/y and ERASE_COLOR; otherwise write_en=0 for those cycles. After slot N_OBJ-1, go to FETCH with slot=0.
- FETCH: obj_req=1 and obj_idx=slot, both held stable until the transfer. On transfer:
  - capture x/y/colour;
  - shadow[slot] becomes {colour!=0, x, y};
  - obj_req drops the next cycle;
  - go to DRAW if colour!=0; otherwise advance the slot and re-request.
- obj_valid while obj_req=0 is ignored. Fetch wait time is unbounded; write_en=0 while waiting.
- DRAW: P cycles of write_en=1 with the captured x/y/colour. Then the next slot goes to FETCH; after the last slot, go to DONE.
- DONE: frame_done=1 and busy=0 for exactly one cycle, then IDLE.
- No back-pressure on the write port: the memory accepts one write per cycle.
- Coordinates are never wrapped.
- The erase/draw ordering guarantees an object drawn in the same place on consecutive frames reappears in the same pass.
- reset_n low mid-pass: the next cycle returns to IDLE with reset output values. The pass is abandoned and no frame_done is issued.

Optional Feature:
RENDER_SPRITE_2X2_EN
- Defined: P=4 and each particle is a 2x2 sprite. Sub-pixel order is (x,y), (x+1,y), (x,y+1), (x+1,y+1).
  - A sub-pixel whose coordinate would exceed 63 gets write_en=0 in its cycle (clipped, no wrap).
  - Erase uses the same pattern and clipping.
- Undefined: P=1, single-pixel draw and erase.

Test Plan:
- Reset, N_OBJ=4, all slots colour 0, frame_start, obj_valid tied high -> zero writes; 4 transfers on idx 0,1,2,3; one frame_done pulse; busy high throughout the pass.
- Slot 2 = (10,20,3'b101), frame 1 -> exactly one write (10,20,101); frame 2 with slot 2 = (11,20,101) -> write (10,20,000) precedes write (11,20,101).
- obj_valid delayed 5 cycles on slot 1 -> obj_req/obj_idx=1 held 5+ cycles, no write_en during the wait, draw follows the transfer.
- frame_start re-pulsed while busy -> ignored: exactly one frame_done; shadow state identical to the single-pass case.
- reset_n low during DRAW of slot 1 -> outputs zero next cycle; the following frame performs no erase writes.
- RENDER_SPRITE_2X2_EN, particle (63,63,3'b010) -> only write (63,63,010); the three out-of-range sub-pixel cycles have write_en=0. Particle (5,5) -> 4 writes in the specified order.
